// File: rtl/parallel_op_join.sv
// Fork a bitwise op across parallel lanes, each with its own delay,
// and join once every lane has completed.
module parallel_op_join #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int DLY_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [CHANNELS*DLY_W-1:0] dly,
  input  logic [1:0]                op,
  input  logic                      abort,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       ch_done,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]          r_a;
  logic [CHANNELS*WIDTH-1:0] r_b;
  logic [1:0]                r_op;
  logic [DLY_W-1:0]          r_cnt [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] r_out;
  logic [CHANNELS-1:0]       r_done;

  logic [CHANNELS-1:0]       w_fin;
  logic                      w_all;
  logic [CHANNELS*WIDTH-1:0] w_res;

  // A lane finishes on the edge its counter is seen at zero.
  always_comb begin
    w_fin = '0;
    w_res = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_fin[i] = ~r_done[i] && (r_cnt[i] == '0);
      case (r_op)
        2'b00:   w_res[i*WIDTH +: WIDTH] = r_a & r_b[i*WIDTH +: WIDTH];
        2'b01:   w_res[i*WIDTH +: WIDTH] = r_a | r_b[i*WIDTH +: WIDTH];
        2'b10:   w_res[i*WIDTH +: WIDTH] = r_a ^ r_b[i*WIDTH +: WIDTH];
        default: w_res[i*WIDTH +: WIDTH] = ~(r_a & r_b[i*WIDTH +: WIDTH]);
      endcase
    end
  end

  assign w_all = &(r_done | w_fin);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort)      w_state_nxt = S_IDLE;
        else if (w_all) w_state_nxt = S_DONE;
      end
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_out  <= '0;
      r_done <= '0;
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_op   <= op;
            r_done <= '0;
            for (int i = 0; i < CHANNELS; i++)
              r_cnt[i] <= dly[i*DLY_W +: DLY_W];
          end
        end
        S_RUN: begin
          // Abort beats any completion landing on the same edge.
          if (abort) begin
            r_done <= '0;
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (w_fin[i]) begin
                r_out[i*WIDTH +: WIDTH] <= w_res[i*WIDTH +: WIDTH];
                r_done[i]               <= 1'b1;
              end else if (!r_done[i]) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
  assign ch_done   = r_done;

endmodule
